// File: rtl/seg_scan_if.sv
// Display scanner bus: value/mask inputs from the host, anode/decoder outputs to the board.
// Pure signal bundle, no latency, no backpressure.
interface seg_scan_if #(
    parameter int DIGITS = 8
);
    logic [4*DIGITS-1:0] data;
    logic                load;
    logic [DIGITS-1:0]   blank_mask;
    logic [DIGITS-1:0]   dp_mask;
    logic                lzs;
    logic [3:0]          num;
    logic [DIGITS-1:0]   an;
    logic                dp_n;
    logic                upd_pending;

    modport master (
        output data, load, blank_mask, dp_mask, lzs,
        input  num, an, dp_n, upd_pending
    );

    modport slave (
        input  data, load, blank_mask, dp_mask, lzs,
        output num, an, dp_n, upd_pending
    );
endinterface

// File: rtl/seg_scan.sv
// Time-multiplexed common-anode 7-seg scanner; double-buffered value swapped at frame wrap.
// All outputs registered (1 cycle from masks); load is always accepted, no backpressure.
module seg_scan #(
    parameter int DIGITS       = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    seg_scan_if.slave   bus
);
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [DIGITS-1:0][3:0] shadow_q, shadow_d;
    logic [DIGITS-1:0][3:0] pending_q, pending_d;
    logic                   pend_vld_q, pend_vld_d;
    logic [3:0]             num_q, num_d;
    logic [DIGITS-1:0]      an_q, an_d;
    logic                   dp_n_q, dp_n_d;
    logic [DIGITS-1:0]      hi_nz;
    logic                   term, wrap, active, nz_acc;

    always_comb begin
        term       = (cnt_q == CNT_LAST);
        wrap       = term && (idx_q == IDX_LAST);
        cnt_d      = term ? '0 : cnt_q + 1'b1;
        idx_d      = idx_q;
        if (term) begin
            idx_d = wrap ? '0 : idx_q + 1'b1;
        end
        shadow_d   = shadow_q;
        pending_d  = pending_q;
        pend_vld_d = pend_vld_q;
        if (bus.load) begin
            pending_d  = bus.data;
            pend_vld_d = 1'b1;
        end
        // A load landing on the wrap cycle bypasses the pending buffer entirely.
        if (wrap) begin
            if (bus.load) begin
                shadow_d = bus.data;
            end else if (pend_vld_q) begin
                shadow_d = pending_q;
            end
            pend_vld_d = 1'b0;
        end
    end

    // hi_nz[i]: some nibble at position i or above is non-zero in the next shadow.
    always_comb begin
        hi_nz  = '0;
        nz_acc = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nz_acc   = nz_acc | (shadow_d[i] != 4'h0);
            hi_nz[i] = nz_acc;
        end
    end

    always_comb begin
        active = (cnt_d >= CNT_BLANK) && !bus.blank_mask[idx_d] &&
                 !(bus.lzs && (idx_d != '0) && !hi_nz[idx_d]);
        num_d  = shadow_d[idx_d];
        an_d   = '1;
        dp_n_d = 1'b1;
        if (active) begin
            an_d[idx_d] = 1'b0;
            dp_n_d      = ~bus.dp_mask[idx_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            shadow_q   <= '0;
            pending_q  <= '0;
            pend_vld_q <= 1'b0;
            num_q      <= 4'h0;
            an_q       <= '1;
            dp_n_q     <= 1'b1;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shadow_q   <= shadow_d;
            pending_q  <= pending_d;
            pend_vld_q <= pend_vld_d;
            num_q      <= num_d;
            an_q       <= an_d;
            dp_n_q     <= dp_n_d;
        end
    end

    assign bus.num         = num_q;
    assign bus.an          = an_q;
    assign bus.dp_n        = dp_n_q;
    assign bus.upd_pending = pend_vld_q;
endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan: frame-position reference model checked every cycle, plus literal spot checks.
module tb_seg_scan;
    localparam int D  = 4;
    localparam int RD = 8;
    localparam int BL = 1;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    seg_scan_if #(.DIGITS(D)) bus ();

    seg_scan #(.DIGITS(D), .REFRESH_DIV(RD), .BLANK_CYCLES(BL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference: position in frame as a plain cycle count, display value as a 16-bit word.
    int unsigned k;
    logic [15:0] m_shadow, m_pend;
    logic        m_pv, m_lzs;
    logic [3:0]  m_bm, m_dm;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k <= 0; m_shadow <= '0; m_pend <= '0; m_pv <= 1'b0;
            m_bm <= '0; m_dm <= '0; m_lzs <= 1'b0;
        end else begin
            if (k == D*RD - 1) begin
                if (bus.load) m_shadow <= bus.data;
                else if (m_pv) m_shadow <= m_pend;
                m_pv <= 1'b0;
                if (bus.load) m_pend <= bus.data;
            end else if (bus.load) begin
                m_pend <= bus.data;
                m_pv   <= 1'b1;
            end
            k      <= (k + 1) % (D*RD);
            m_bm   <= bus.blank_mask;
            m_dm   <= bus.dp_mask;
            m_lzs  <= bus.lzs;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    int          ci, cc;
    logic [3:0]  e_num, e_an;
    logic        e_dp, act_d, supp;

    always @(posedge clk) begin
        #2;
        cc    = int'(k % RD);
        ci    = int'(k / RD);
        e_num = 4'((m_shadow >> (4*ci)) & 16'hF);
        supp  = m_lzs && (ci > 0) && ((m_shadow >> (4*ci)) == 16'h0);
        act_d = (cc >= BL) && !m_bm[ci] && !supp;
        e_an  = act_d ? ~(4'b0001 << ci) : 4'hF;
        e_dp  = act_d ? ~m_dm[ci] : 1'b1;
        check("model_num", bus.num, e_num);
        check("model_an", bus.an, e_an);
        check("model_dp", bus.dp_n, e_dp);
        check("model_upd", bus.upd_pending, m_pv);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic goto(input int i, input int c);
        int n = 0;
        do begin
            step(1);
            n++;
        end while (!((k / RD) == i && (k % RD) == c) && n < 100);
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL goto: slot %0d/%0d not reached, got k=%0d", i, c, k);
        end
    endtask

    task automatic load(input logic [15:0] v);
        bus.data = v; bus.load = 1'b1;
        step(1);
        bus.load = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.load = 1'b0; bus.data = '0; bus.blank_mask = '0; bus.dp_mask = '0; bus.lzs = 1'b0;
        step(3);
        check("rst_an", bus.an, 4'hF);
        check("rst_dp", bus.dp_n, 1'b1);
        check("rst_num", bus.num, 4'h0);
        check("rst_upd", bus.upd_pending, 1'b0);
        rst_n = 1'b1;
        step(1);  check("scan_d0_first", bus.an, 4'b1110);
        step(6);  check("scan_d0_last", bus.an, 4'b1110);
        step(1);  check("scan_blank1", bus.an, 4'b1111);
        step(1);  check("scan_d1", bus.an, 4'b1101);
        check("scan_num0", bus.num, 4'h0);
        step(22); check("scan_d3_last", bus.an, 4'b0111);
        step(1);  check("scan_wrap_blank", bus.an, 4'b1111);

        step(12);
        load(16'h1234);
        check("ld_upd", bus.upd_pending, 1'b1);
        goto(0, 1); check("ld_num0", bus.num, 4'h4); check("ld_upd_clr", bus.upd_pending, 1'b0);
        goto(1, 1); check("ld_num1", bus.num, 4'h3);
        goto(3, 4); check("ld_num3", bus.num, 4'h1); check("ld_an3", bus.an, 4'b0111);

        step(1);
        load(16'hAAAA);
        load(16'hBEEF);
        goto(0, 2); check("ml_num0", bus.num, 4'hF);
        goto(1, 2); check("ml_num1", bus.num, 4'hE);
        goto(3, 7);
        load(16'h5555);
        check("byp_num", bus.num, 4'h5);
        check("byp_upd", bus.upd_pending, 1'b0);
        check("byp_an", bus.an, 4'hF);

        bus.lzs = 1'b1;
        load(16'h0070);
        goto(0, 0);
        goto(0, 3); check("lzs_an0", bus.an, 4'b1110); check("lzs_num0", bus.num, 4'h0);
        goto(1, 3); check("lzs_an1", bus.an, 4'b1101); check("lzs_num1", bus.num, 4'h7);
        goto(2, 3); check("lzs_an2", bus.an, 4'hF);
        goto(3, 3); check("lzs_an3", bus.an, 4'hF);
        bus.lzs = 1'b0;
        goto(2, 3); check("nolzs_an2", bus.an, 4'b1011);
        goto(3, 3); check("nolzs_an3", bus.an, 4'b0111);

        bus.blank_mask = 4'b0010; bus.dp_mask = 4'b0100;
        goto(1, 3); check("msk_an1", bus.an, 4'hF);
        goto(2, 0); check("msk_dp_blank", bus.dp_n, 1'b1);
        goto(2, 3); check("msk_dp2", bus.dp_n, 1'b0); check("msk_an2", bus.an, 4'b1011);
        goto(3, 3); check("msk_dp3", bus.dp_n, 1'b1);
        bus.blank_mask = '0; bus.dp_mask = '0;

        goto(1, 0);
        load(16'h9999);
        goto(2, 3); check("mr_upd_pre", bus.upd_pending, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mr_an", bus.an, 4'hF);
        check("mr_dp", bus.dp_n, 1'b1);
        check("mr_num", bus.num, 4'h0);
        check("mr_upd", bus.upd_pending, 1'b0);
        step(1);
        rst_n = 1'b1;
        step(1);  check("mr_restart_an", bus.an, 4'b1110); check("mr_restart_num", bus.num, 4'h0);
        goto(0, 0); check("mr_lost_upd", bus.upd_pending, 1'b0);
        goto(2, 3); check("mr_lost_num", bus.num, 4'h0);

        for (int n = 0; n < 2000; n++) begin
            bus.load = ($urandom_range(0, 9) == 0);
            for (int j = 0; j < D; j++)
                bus.data[4*j +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            if ($urandom_range(0, 15) == 0) bus.blank_mask = 4'($urandom);
            if ($urandom_range(0, 15) == 0) bus.dp_mask = 4'($urandom);
            if ($urandom_range(0, 31) == 0) bus.lzs = ~bus.lzs;
            step(1);
        end
        bus.load = 1'b0;
        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
